// File: rtl/mod3_pkg.sv
// Shared types and the mod-3 adder for the streaming residue datapath.
package mod3_pkg;

    typedef logic [1:0] residue_t;

    localparam residue_t RES0 = 2'd0;
    localparam residue_t RES1 = 2'd1;
    localparam residue_t RES2 = 2'd2;

    typedef enum logic {
        ST_ACCUM,
        ST_RESULT
    } state_t;

    // Operands are always canonical (0..2), so one conditional subtract suffices.
    function automatic residue_t mod3_add(input residue_t a, input residue_t b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/byte_mod3.sv
// Combinational byte-to-residue reducer: each bit pair is a base-4 digit,
// and 4 = 1 (mod 3), so the residue is the mod-3 sum of the digits.
module byte_mod3
    import mod3_pkg::*;
(
    input  logic [7:0] data,
    output residue_t   residue
);

    residue_t digit [4];
    residue_t sum_lo;
    residue_t sum_hi;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            // Pair value b0 + 2*b1 with 2 = -1, so the digit is b0 - b1.
            assign digit[gi] = (data[2*gi] & ~data[2*gi+1]) ? RES1 :
                               (data[2*gi+1] & ~data[2*gi]) ? RES2 : RES0;
        end
    endgenerate

    assign sum_lo  = mod3_add(digit[0], digit[1]);
    assign sum_hi  = mod3_add(digit[2], digit[3]);
    assign residue = mod3_add(sum_lo, sum_hi);

endmodule

// File: rtl/mod3_stream_residue.sv
// Streams an MSB-first byte sequence and emits its residue mod 3 per frame,
// holding each result until downstream accepts it.
module mod3_stream_residue
    import mod3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_residue,
    output logic             res_zero,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    residue_t           acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_acc_reg, ovf_acc_next;
    logic               res_valid_reg, res_valid_next;
    residue_t           res_residue_reg, res_residue_next;
    logic               res_zero_reg, res_zero_next;
    logic [CNT_W-1:0]   res_count_reg, res_count_next;
    logic               res_ovf_reg, res_ovf_next;

    residue_t           byte_res;
    residue_t           acc_sum;
    logic               cnt_at_max;
    logic [CNT_W-1:0]   cnt_sat;
    logic               accept;

    byte_mod3 u_byte_mod3 (
        .data    (in_data),
        .residue (byte_res)
    );

    // 256 = 1 (mod 3): shifting in a byte just adds its residue.
    assign acc_sum    = mod3_add(acc_reg, byte_res);
    assign cnt_at_max = (cnt_reg == CNT_MAX);
    assign cnt_sat    = cnt_at_max ? cnt_reg : cnt_reg + 1'b1;
    assign in_ready   = (state_reg == ST_ACCUM) || res_ready;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_next       = state_reg;
        acc_next         = acc_reg;
        cnt_next         = cnt_reg;
        ovf_acc_next     = ovf_acc_reg;
        res_valid_next   = res_valid_reg;
        res_residue_next = res_residue_reg;
        res_zero_next    = res_zero_reg;
        res_count_next   = res_count_reg;
        res_ovf_next     = res_ovf_reg;

        if (state_reg == ST_RESULT && res_ready) begin
            res_valid_next = 1'b0;
            state_next     = ST_ACCUM;
        end

        // A beat taken in the consuming cycle overrides the release above.
        if (accept) begin
            if (in_last) begin
                res_residue_next = acc_sum;
                res_zero_next    = (acc_sum == RES0);
                res_count_next   = cnt_sat;
                res_ovf_next     = ovf_acc_reg | cnt_at_max;
                res_valid_next   = 1'b1;
                acc_next         = RES0;
                cnt_next         = '0;
                ovf_acc_next     = 1'b0;
                state_next       = ST_RESULT;
            end else begin
                acc_next     = acc_sum;
                cnt_next     = cnt_sat;
                ovf_acc_next = ovf_acc_reg | cnt_at_max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_ACCUM;
            acc_reg         <= RES0;
            cnt_reg         <= '0;
            ovf_acc_reg     <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_residue_reg <= RES0;
            res_zero_reg    <= 1'b0;
            res_count_reg   <= '0;
            res_ovf_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            acc_reg         <= acc_next;
            cnt_reg         <= cnt_next;
            ovf_acc_reg     <= ovf_acc_next;
            res_valid_reg   <= res_valid_next;
            res_residue_reg <= res_residue_next;
            res_zero_reg    <= res_zero_next;
            res_count_reg   <= res_count_next;
            res_ovf_reg     <= res_ovf_next;
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_residue = res_residue_reg;
    assign res_zero    = res_zero_reg;
    assign res_count   = res_count_reg;
    assign res_ovf     = res_ovf_reg;

endmodule

// File: tb/tb_mod3_stream_residue.sv
// Randomised and directed frames against an arithmetic mod-3 model, with a
// queue-based scoreboard popped on every result handshake.
module tb_mod3_stream_residue;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int res;
        int cnt;
        int ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_residue;
    logic             res_zero;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    int vectors = 0;
    int miscompares = 0;
    int rr_mode = 0;

    exp_t       exp_q[$];
    logic [7:0] frame[$];

    mod3_stream_residue #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_residue (res_residue),
        .res_zero    (res_zero),
        .res_count   (res_count),
        .res_ovf     (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the frame as a big-endian integer, reduced with plain arithmetic.
    function automatic exp_t model_frame();
        exp_t e;
        int   r = 0;
        foreach (frame[i]) r = (r * 256 + int'(frame[i])) % 3;
        e.res = r;
        e.cnt = (frame.size() > CNT_MAX) ? CNT_MAX : frame.size();
        e.ovf = (frame.size() > CNT_MAX) ? 1 : 0;
        return e;
    endfunction

    // res_ready driver
    initial begin
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'b0;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        bit               hold;
        logic [CNT_W+3:0] held;
        exp_t             e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'({res_residue, res_zero, res_count, res_ovf}), int'(held));
            end
            hold = res_valid && !res_ready;
            held = {res_residue, res_zero, res_count, res_ovf};
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got residue %0d with no frame pending at %0t",
                             res_residue, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("residue", int'(res_residue), e.res);
                    chk("zero", int'(res_zero), (e.res == 0) ? 1 : 0);
                    chk("count", int'(res_count), e.cnt);
                    chk("ovf", int'(res_ovf), e.ovf);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
    endtask

    task automatic send_beat(input logic [7:0] b, input logic l);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        frame.push_back(b);
        if (l) begin
            exp_q.push_back(model_frame());
            frame.delete();
            #1;
            chk("latency_valid", int'(res_valid), 1);
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        if (n == 1) send_beat(b0, 1'b1);
        if (n == 2) begin send_beat(b0, 1'b0); send_beat(b1, 1'b1); end
        if (n == 3) begin send_beat(b0, 1'b0); send_beat(b1, 1'b0); send_beat(b2, 1'b1); end
    endtask

    task automatic check_now(input string name, input int r, input int c, input int o);
        chk({name, "_residue"}, int'(res_residue), r);
        chk({name, "_zero"}, int'(res_zero), (r == 0) ? 1 : 0);
        chk({name, "_count"}, int'(res_count), c);
        chk({name, "_ovf"}, int'(res_ovf), o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        frame.delete();
        exp_q.delete();
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_outputs", int'({res_residue, res_zero, res_count, res_ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_long(input int n);
        for (int i = 0; i < n; i++) send_beat(8'($urandom), (i == n - 1) ? 1'b1 : 1'b0);
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_outputs", int'({res_residue, res_zero, res_count, res_ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte, then the result is gone the following cycle
        rr_mode = 0;
        send_frame(1, 8'h07, 8'h00, 8'h00);
        check_now("f07", 1, 1, 0);
        idle(1);
        @(posedge clk);
        #1;
        chk("f07_drop_valid", int'(res_valid), 0);

        send_frame(2, 8'hFF, 8'hFF, 8'h00);
        check_now("fffff", 0, 2, 0);
        idle(2);
        send_frame(2, 8'h01, 8'h00, 8'h00);
        check_now("f0100", 1, 2, 0);
        idle(2);

        // Backpressure: result held, next beat refused until the handshake
        rr_mode = 1;
        send_frame(3, 8'h02, 8'h02, 8'h02);
        check_now("f020202", 0, 3, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h05;
        in_last  = 1'b1;
        repeat (5) begin
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        rr_mode = 0;
        send_beat(8'h05, 1'b1);
        check_now("f05_after_bp", 2, 1, 0);

        // Back-to-back single-byte frames with no bubble
        send_beat(8'h05, 1'b1);
        send_beat(8'h0B, 1'b1);
        check_now("f0b", 2, 1, 0);
        idle(2);

        // Count saturation boundary
        send_long(CNT_MAX);
        chk("sat255_count", int'(res_count), CNT_MAX);
        chk("sat255_ovf", int'(res_ovf), 0);
        send_long(CNT_MAX + 1);
        chk("sat256_count", int'(res_count), CNT_MAX);
        chk("sat256_ovf", int'(res_ovf), 1);
        send_long(300);
        chk("sat300_ovf", int'(res_ovf), 1);
        send_frame(1, 8'h03, 8'h00, 8'h00);
        check_now("f03_after_sat", 0, 1, 0);
        idle(2);

        // Reset mid-frame discards the partial frame
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        do_reset();
        send_frame(1, 8'h04, 8'h00, 8'h00);
        check_now("f04_after_rst", 1, 1, 0);
        idle(2);

        // Reset with a pending result
        rr_mode = 1;
        send_frame(1, 8'h09, 8'h00, 8'h00);
        idle(2);
        do_reset();
        rr_mode = 0;
        idle(3);

        // Random frames under random backpressure
        rr_mode = 2;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_beat(8'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        rr_mode = 0;
        idle(1);
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
